// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR generator and its stream checker.
package lfsr_pkg;

    localparam int              LFSR_W    = 4;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b0011;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 4'b0001;
    localparam int              PERIOD_W  = 5;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // Galois-style step: shift left, fold the taps in when the MSB falls out.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
        return {x[LFSR_W-2:0], 1'b0} ^ (x[LFSR_W-1] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/lfsr_period_meter.sv
// Measures the number of samples between successive seed values while the
// checker is locked; the first seed after lock only arms the measurement.
module lfsr_period_meter
    import lfsr_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic                active,
    input  logic [LFSR_W-1:0]   in_q,
    input  logic                clear,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    localparam logic [PERIOD_W-1:0] SAT = '1;

    logic [PERIOD_W-1:0] since_q;
    logic                armed_q;
    logic                seed_hit;

    assign seed_hit = (in_q == LFSR_SEED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            since_q      <= '0;
            armed_q      <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            if (sample_en) begin
                if (!active) begin
                    armed_q <= 1'b0;
                    since_q <= '0;
                end else if (seed_hit) begin
                    armed_q <= 1'b1;
                    since_q <= '0;
                    // The count includes the seed sample that closes the interval.
                    if (armed_q) begin
                        period       <= (since_q == SAT) ? SAT : since_q + PERIOD_W'(1);
                        period_valid <= 1'b1;
                    end
                end else if (since_q != SAT) begin
                    since_q <= since_q + PERIOD_W'(1);
                end
            end
            if (clear) begin
                period       <= '0;
                period_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Stream checker for a 4-bit LFSR: searches for LOCK_COUNT good transitions,
// then flywheels an expected value and counts mismatches until lock is lost.
module lfsr_stream_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_q,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [4:0]       period,
    output logic             period_valid
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

    // in_valid qualifies in_q; there is no back-pressure, every valid sample
    // is consumed on the rising edge that sees in_valid=1.

    chk_state_t         state_q;
    chk_state_t         state_nxt;
    logic [LFSR_W-1:0]  prev_q;
    logic [LFSR_W-1:0]  expected_q;
    logic               prev_vld_q;
    logic [MATCH_W-1:0] match_cnt_q;
    logic [MATCH_W-1:0] match_cnt_inc;
    logic [MISS_W-1:0]  miss_cnt_q;
    logic [MISS_W-1:0]  miss_cnt_inc;
    logic               search_match;
    logic               lock_hit;
    logic               locked_miss;
    logic               loss_hit;

    always_comb begin
        match_cnt_inc = match_cnt_q + MATCH_W'(1);
        miss_cnt_inc  = miss_cnt_q + MISS_W'(1);
        search_match  = prev_vld_q && (in_q == lfsr_next(prev_q)) && (in_q != '0);
        lock_hit      = search_match && (match_cnt_inc == MATCH_W'(LOCK_COUNT));
        // The all-zero lock-up value can never equal a valid expected value.
        locked_miss   = (in_q != expected_q) || (in_q == '0);
        loss_hit      = locked_miss && (miss_cnt_inc == MISS_W'(LOSS_COUNT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (in_valid) begin
            case (state_q)
                SEARCH:  if (lock_hit) state_nxt = LOCKED;
                LOCKED:  if (loss_hit) state_nxt = SEARCH;
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                if (state_q == SEARCH) begin
                    prev_q      <= in_q;
                    prev_vld_q  <= 1'b1;
                    match_cnt_q <= (search_match && !lock_hit) ? match_cnt_inc : '0;
                    if (lock_hit) begin
                        expected_q <= lfsr_next(in_q);
                    end
                end else begin
                    // Flywheel: expected advances whether or not the sample matched.
                    expected_q <= lfsr_next(expected_q);
                    if (locked_miss) begin
                        err_pulse <= 1'b1;
                        if (err_count != {ERR_W{1'b1}}) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        if (loss_hit) begin
                            miss_cnt_q  <= '0;
                            match_cnt_q <= '0;
                            prev_q      <= in_q;
                            prev_vld_q  <= 1'b1;
                        end else begin
                            miss_cnt_q <= miss_cnt_inc;
                        end
                    end else begin
                        miss_cnt_q <= '0;
                    end
                end
            end
            if (clear) begin
                err_count <= '0;
            end
        end
    end

    lfsr_period_meter u_period_meter (
        .clk          (clk),
        .reset        (reset),
        .sample_en    (in_valid),
        .active       (locked),
        .in_q         (in_q),
        .clear        (clear),
        .period       (period),
        .period_valid (period_valid)
    );

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: lock acquisition, flywheel errors,
// loss and re-lock, lock-up input, sparse valid, async reset and clear.
module tb_lfsr_stream_checker;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_q;
    logic       clear;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [4:0] period;
    logic       period_valid;

    int         n_vec;
    int         n_fail;
    logic [3:0] seq [15];

    lfsr_stream_checker #(
        .LOCK_COUNT (4),
        .LOSS_COUNT (2),
        .ERR_W      (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_q         (in_q),
        .clear        (clear),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .period       (period),
        .period_valid (period_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Drive one cycle; outputs are sampled 1ns after the edge on return.
    task automatic apply(input logic [3:0] v, input logic vld, input logic clr);
        in_q     = v;
        in_valid = vld;
        clear    = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic feed(input int from, input int to);
        for (int k = from; k <= to; k++) apply(seq[k % 15], 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({locked, err_pulse, err_count, period, period_valid} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_async outs=%h expected=0", {locked, err_pulse, err_count, period, period_valid});
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if ({locked, err_pulse, err_count, period, period_valid} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_hold outs=%h expected=0", {locked, err_pulse, err_count, period, period_valid});
        end
        reset = 1'b1;
    endtask

    task automatic test_lock_acquire();
        logic exp_lock;
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            apply(seq[k % 15], 1'b1, 1'b0);
            exp_lock = (k >= 4);
            n_vec++;
            if (locked !== exp_lock) begin
                n_fail++;
                $display("FAIL lock_locked k=%0d got=%0b expected=%0b", k, locked, exp_lock);
            end
            n_vec++;
            if (err_count !== 8'd0 || err_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_err k=%0d count=%0d pulse=%0b expected 0/0", k, err_count, err_pulse);
            end
            if (k < 30) begin
                n_vec++;
                if (period_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lock_pv_early k=%0d got=%0b expected=0", k, period_valid);
                end
            end
        end
        n_vec++;
        if (period !== 5'd15 || period_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_period got=%0d/%0b expected=15/1", period, period_valid);
        end
    endtask

    task automatic test_single_error();
        do_reset();
        feed(0, 16);
        apply(4'b0101, 1'b1, 1'b0);
        n_vec++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hit pulse=%0b count=%0d locked=%0b expected 1/1/1", err_pulse, err_count, locked);
        end
        apply(4'b1000, 1'b1, 1'b0);
        n_vec++;
        if (err_pulse !== 1'b0 || err_count !== 8'd1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL single_after pulse=%0b count=%0d locked=%0b expected 0/1/1", err_pulse, err_count, locked);
        end
        feed(19, 22);
        n_vec++;
        if (err_count !== 8'd1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL single_flywheel count=%0d locked=%0b expected 1/1", err_count, locked);
        end
    endtask

    task automatic test_double_error_relock();
        do_reset();
        feed(0, 4);
        apply(4'b1111, 1'b1, 1'b0);
        n_vec++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL double_first pulse=%0b count=%0d locked=%0b expected 1/1/1", err_pulse, err_count, locked);
        end
        apply(4'b0010, 1'b1, 1'b0);
        n_vec++;
        if (err_pulse !== 1'b1 || err_count !== 8'd2 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL double_second pulse=%0b count=%0d locked=%0b expected 1/2/0", err_pulse, err_count, locked);
        end
        for (int k = 7; k <= 11; k++) begin
            apply(seq[k], 1'b1, 1'b0);
            n_vec++;
            if (locked !== (k == 11) || err_pulse !== 1'b0 || err_count !== 8'd2) begin
                n_fail++;
                $display("FAIL relock k=%0d locked=%0b pulse=%0b count=%0d expected %0b/0/2",
                         k, locked, err_pulse, err_count, (k == 11));
            end
        end
    endtask

    task automatic test_zero_lockup();
        do_reset();
        for (int c = 0; c < 40; c++) begin
            apply(4'b0000, 1'b1, 1'b0);
            n_vec++;
            if (locked !== 1'b0 || err_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_cycle c=%0d locked=%0b pulse=%0b expected 0/0", c, locked, err_pulse);
            end
        end
        n_vec++;
        if (err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL zero_count got=%0d expected=0", err_count);
        end
    endtask

    task automatic test_sparse_valid();
        logic exp_lock;
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            exp_lock = (k >= 5);
            for (int i = 0; i < 2; i++) begin
                apply(4'($urandom_range(0, 15)), 1'b0, 1'b0);
                n_vec++;
                if (err_pulse !== 1'b0 || locked !== exp_lock || period_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sparse_idle k=%0d pulse=%0b locked=%0b pv=%0b expected 0/%0b/0",
                             k, err_pulse, locked, period_valid, exp_lock);
                end
            end
            apply(seq[k % 15], 1'b1, 1'b0);
            exp_lock = (k >= 4);
            n_vec++;
            if (locked !== exp_lock || err_pulse !== 1'b0 || err_count !== 8'd0) begin
                n_fail++;
                $display("FAIL sparse_sample k=%0d locked=%0b pulse=%0b count=%0d expected %0b/0/0",
                         k, locked, err_pulse, err_count, exp_lock);
            end
        end
        n_vec++;
        if (period !== 5'd15 || period_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sparse_period got=%0d/%0b expected=15/1", period, period_valid);
        end
    endtask

    task automatic test_async_reset_mid_lock();
        do_reset();
        feed(0, 30);
        apply(4'b0110, 1'b1, 1'b0);
        n_vec++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b1 || period_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre pulse=%0b count=%0d locked=%0b pv=%0b expected 1/1/1/1",
                     err_pulse, err_count, locked, period_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({locked, err_pulse, err_count, period, period_valid} !== 16'h0) begin
            n_fail++;
            $display("FAIL arst_mid outs=%h expected=0", {locked, err_pulse, err_count, period, period_valid});
        end
        @(negedge clk);
        reset = 1'b1;
        feed(2, 5);
        n_vec++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_research locked=%0b expected=0", locked);
        end
    endtask

    task automatic test_clear_with_mismatch();
        do_reset();
        feed(0, 30);
        apply(4'b0000, 1'b1, 1'b1);
        n_vec++;
        if (err_pulse !== 1'b1 || err_count !== 8'd0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_mis pulse=%0b count=%0d locked=%0b expected 1/0/1", err_pulse, err_count, locked);
        end
        n_vec++;
        if (period_valid !== 1'b0 || period !== 5'd0) begin
            n_fail++;
            $display("FAIL clear_period got=%0d/%0b expected=0/0", period, period_valid);
        end
        apply(4'b0000, 1'b1, 1'b0);
        n_vec++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_followup pulse=%0b count=%0d locked=%0b expected 1/1/0", err_pulse, err_count, locked);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_q     = 4'b0000;
        clear    = 1'b0;
        seq      = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                     4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};
        test_reset();
        test_lock_acquire();
        test_single_error();
        test_double_error_relock();
        test_zero_lockup();
        test_sparse_valid();
        test_async_reset_mid_lock();
        test_clear_with_mismatch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lfsr_stream_checker.md
LFSR_STREAM_CHECKER -- requirements
Module: lfsr_stream_checker

Interface
REQ-001 Parameter: LOCK_COUNT, default 4, consecutive correct transitions needed to acquire lock.
REQ-002 Parameter: LOSS_COUNT, default 2, consecutive mismatches while locked that drop lock.
REQ-003 Parameter: ERR_W, default 8, width of the error counter.
REQ-004 Port: clk  input  1  rising-edge system clock.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: in_valid  input  1  in_q holds a stream sample this cycle.
REQ-007 Port: in_q  input  4  sample from the upstream 4-bit LFSR.
REQ-008 Port: clear  input  1  synchronous clear of err_count, period and period_valid.
REQ-009 Port: locked  output  1  checker is synchronised to the stream.
REQ-010 Port: err_pulse  output  1  one-cycle flag marking a mismatch detected while locked.
REQ-011 Port: err_count  output  ERR_W  saturating count of locked mismatches.
REQ-012 Port: period  output  5  last measured sample count between occurrences of 4'b0001.
REQ-013 Port: period_valid  output  1  period holds a measurement.

Function
REQ-014 The checker SHALL compute next(x) = {x[2:0],1'b0} XOR (x[3] ? 4'b0011 : 4'b0000), which gives 0001,0010,0100,1000,0011,...,1001,0001 with a period of 15.
REQ-015 All outputs SHALL be registered, and every response to an accepted sample SHALL appear on the clock edge that samples in_valid=1.
REQ-016 When in_valid=0, all state SHALL hold and err_pulse SHALL be 0.
REQ-017 The FSM SHALL have exactly two states, SEARCH and LOCKED; locked = (state == LOCKED).
REQ-018 In SEARCH:
  - each sample is stored as prev.
  - if a prev exists, in_q == next(prev) and in_q != 0, match_cnt increments; otherwise match_cnt is cleared.
  - when match_cnt reaches LOCK_COUNT, the FSM enters LOCKED and sets expected = next(in_q).
REQ-019 In SEARCH, err_pulse and err_count SHALL NOT change.
REQ-020 In LOCKED, expected SHALL advance to next(expected) on every accepted sample regardless of match (flywheel).
  - A single corrupt sample therefore produces exactly one error.
REQ-021 In LOCKED, a sample with in_q != expected SHALL assert err_pulse, increment err_count (saturating at 2^ERR_W-1) and increment miss_cnt.
REQ-022 In LOCKED, a matching sample SHALL clear miss_cnt.
REQ-023 When miss_cnt reaches LOSS_COUNT, the FSM SHALL return to SEARCH with match_cnt=0, prev=in_q and period_valid retained.
REQ-024 in_q=4'b0000 (lock-up state) SHALL always be treated as a mismatch and never counts toward lock.
REQ-025 Period measurement SHALL run only in LOCKED:
  - a sample counter counts accepted samples since the last 0001.
  - on each later 0001, period is loaded with that count (saturating at 31), period_valid is set and the counter restarts.
  - the first 0001 after lock only starts the counter.
REQ-026 If clear and a mismatch occur in the same cycle, clear SHALL win:
  - err_count is 0 and period_valid is 0.
  - err_pulse still asserts and the FSM still processes the sample.

Reset
REQ-027 reset=0 SHALL asynchronously force state=SEARCH, match_cnt=0, miss_cnt=0, no prev, locked=0, err_pulse=0, err_count=0, period=0, period_valid=0, at any time including mid-lock.
REQ-028 Deassertion SHALL be synchronised by the system; the first sample is accepted on the first rising edge with reset=1.

Structure
REQ-029 Shared package lfsr_pkg SHALL hold LFSR_W=4, LFSR_TAPS=4'b0011, LFSR_SEED=4'b0001, the SEARCH/LOCKED state type and the next() function, shared with the upstream generator.
REQ-030 Period measurement SHALL be a separate sub-module, lfsr_period_meter; everything else SHALL be in one module.

Verification
REQ-031 Reset, then feed the 0001... sequence with in_valid=1 every cycle:
  - locked rises at the edge accepting the 5th sample (0011).
  - err_count stays 0.
  - after the second post-lock 0001, period=15 and period_valid=1.
REQ-032 While locked, replace one 0100 with 0101:
  - exactly one err_pulse; err_count=1.
  - locked stays 1 and the following 1000 causes no error.
REQ-033 While locked, corrupt two consecutive samples:
  - two err_pulses; err_count=2; locked falls.
  - re-lock occurs after LOCK_COUNT further correct transitions.
REQ-034 Constant in_q=0000 for 40 cycles -> locked stays 0 and err_count stays 0.
REQ-035 Repeat REQ-031 with in_valid high every third cycle -> identical lock point and values in sample order, with no err_pulse on idle cycles.
REQ-036 Two edge cases:
  - reset=0 asserted mid-lock, between clock edges -> all outputs 0 immediately.
  - clear asserted in the same cycle as a mismatch -> err_count=0 and err_pulse=1.
